bus_cycle_seq: RTL and testbench
================================

BUS_CYCLE_SEQ -- requirements
Module: bus_cycle_seq

Interface
REQ-001 Parameter: FAST_DIV, 2, hsclk cycles per fast CPU half-phase; legal range 2..8.
REQ-002 Parameter: SYNC_STAGES, 2, flip-flop stages in the bbc_phi0 synchroniser; legal range 2..3.
REQ-003 Clocking is decided: one clock (hsclk); reset (rst) is synchronous and active-high.
REQ-004 Port: hsclk  in  1  high-speed oscillator clock; sole clock.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: bbc_phi0  in  1  host phi0 (filtered), asynchronous to hsclk.
REQ-007 Port: bbc_rdy  in  1  host RDY; low extends the host cycle.
REQ-008 Port: cpu_vda, cpu_vpa, cpu_rnw  in  1 each  65816 cycle qualifiers.
REQ-009 Port: sel_bbc, sel_ram  in  1 each  decoder outputs for the current address.
REQ-010 Port: cpu_phi2  out  1  generated 65816 clock.
REQ-011 Port: ram_ceb, ram_oeb, ram_web  out  1 each  SRAM strobes, active-low.
REQ-012 Port: bbc_cyc  out  1  host bus cycle in progress; host address/RnW driven.
REQ-013 Port: bbc_dout_en  out  1  drive CPU write data onto bbc_d.
REQ-014 Port: rd_latch  out  1  one-hsclk pulse that captures bbc_d into the read latch.
REQ-015 Port: dsel_latch  out  1  CPU data bus sourced from the read latch.

Function
REQ-016 States SHALL be F_LO, F_HI, S_WAIT, S_PH1, S_PH2, S_END; a modulo-FAST_DIV counter SHALL time F_LO and F_HI.
REQ-017 phi0_r / phi0_f SHALL be one-hsclk pulses marking rise/fall of synchronised bbc_phi0; latency SHALL be SYNC_STAGES+1 hsclk from the pin edge.
REQ-018 F_LO: cpu_phi2=0; on its last count, (cpu_vda|cpu_vpa)&sel_bbc -> S_WAIT, else -> F_HI.
REQ-019 F_HI: cpu_phi2=1; after FAST_DIV cycles -> F_LO; cycle counter cleared on every state change.
REQ-020 When both sel_bbc and sel_ram are set, sel_bbc SHALL win; when neither is set or vda=vpa=0, the cycle SHALL run fast with no RAM strobes.
REQ-021 ram_ceb SHALL be 0 in F_LO/F_HI when sel_ram&~sel_bbc&(vda|vpa).
REQ-022 ram_oeb SHALL be 0 throughout F_HI when ram_ceb=0 and cpu_rnw=1.
REQ-023 ram_web SHALL be 0 during F_HI counts 0..FAST_DIV-2 when ram_ceb=0 and cpu_rnw=0, giving one cycle of data hold.
REQ-024 S_WAIT: cpu_phi2=0; on phi0_f -> S_PH1; phi0_r SHALL be ignored, giving alignment to a full host cycle.
REQ-025 S_PH1: cpu_phi2=0, bbc_cyc=1; on phi0_r -> S_PH2.
REQ-026 S_PH2: cpu_phi2=1, bbc_cyc=1, bbc_dout_en=~cpu_rnw.
REQ-027 S_PH2 on phi0_f: if bbc_rdy=0, re-enter S_PH1 for a host cycle repeat; else assert rd_latch (if cpu_rnw) and -> S_END.
REQ-028 S_END: one hsclk; cpu_phi2=1, dsel_latch=cpu_rnw, bbc_cyc=0; then -> F_LO with counter 0.
REQ-029 phi0_r and phi0_f SHALL never coincide; no other simultaneous-event priority applies.
REQ-030 All outputs SHALL be registered and glitch-free.

Reset
REQ-031 While rst=1: state=F_LO, counter=0, synchroniser cleared.
REQ-032 While rst=1, outputs SHALL be cpu_phi2=0, ram_ceb=ram_oeb=ram_web=1, bbc_cyc=bbc_dout_en=rd_latch=dsel_latch=0.
REQ-033 rst asserted mid host cycle SHALL abort it in the same cycle with no rd_latch pulse.

Structure
REQ-034 Package l1b_pkg SHALL hold the state enum and default FAST_DIV/SYNC_STAGES constants.
REQ-035 One sub-module, phi0_edge_sync (synchroniser plus rise/fall pulse), SHALL be instantiated once.

Verification
REQ-036 FAST_DIV=2, sel_ram=1, rnw=1, vda=1 -> cpu_phi2 period 4 hsclk; ram_ceb=0 for 4 cycles; ram_oeb=0 for the 2 F_HI cycles; ram_web stays 1.
REQ-037 Same with rnw=0 -> ram_web=0 for exactly 1 hsclk (F_HI count 0); ram_oeb stays 1.
REQ-038 phi0 period 16 hsclk, sel_bbc=1, rnw=1 -> S_WAIT to next phi0_f, then bbc_cyc=1 for 16 cycles, one rd_latch pulse, dsel_latch=1 for 1 cycle, then a fast cycle resumes.
REQ-039 bbc_rdy=0 for one host cycle during a BBC read -> two S_PH1/S_PH2 passes, rd_latch only at the second phi0_f.
REQ-040 rst=1 asserted during S_PH2 -> next cycle all outputs at reset values, state F_LO, no rd_latch.
REQ-041 sel_bbc=sel_ram=1, BBC write -> ram_ceb stays 1; bbc_dout_en=1 only during S_PH2.

Source files
------------

// File: rtl/l1b_pkg.sv
// Shared types and defaults for the 65816 bus cycle sequencer.
// Holds the sequencer state encoding and the registered output bundle.
package l1b_pkg;

    localparam int FAST_DIV_DEF    = 2;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        F_LO,
        F_HI,
        S_WAIT,
        S_PH1,
        S_PH2,
        S_END
    } seq_state_t;

    typedef struct packed {
        logic cpu_phi2;
        logic ram_ceb;
        logic ram_oeb;
        logic ram_web;
        logic bbc_cyc;
        logic bbc_dout_en;
        logic rd_latch;
        logic dsel_latch;
    } bus_out_t;

    localparam bus_out_t OUT_RST = '{
        cpu_phi2:    1'b0,
        ram_ceb:     1'b1,
        ram_oeb:     1'b1,
        ram_web:     1'b1,
        bbc_cyc:     1'b0,
        bbc_dout_en: 1'b0,
        rd_latch:    1'b0,
        dsel_latch:  1'b0
    };

    function automatic logic is_fast(input seq_state_t s);
        return (s == F_LO) || (s == F_HI);
    endfunction

    function automatic logic phi2_high(input seq_state_t s);
        return (s == F_HI) || (s == S_PH2) || (s == S_END);
    endfunction

endpackage

// File: rtl/phi0_edge_sync.sv
// Brings host phi0 into the hsclk domain and marks its edges
// with single-cycle registered rise/fall pulses.
module phi0_edge_sync
    import l1b_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic hsclk,
    input  logic rst,
    input  logic bbc_phi0,
    output logic phi0_r,
    output logic phi0_f
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   phi0_d;
    logic                   phi0_s;

    assign phi0_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge hsclk) begin
        if (rst) begin
            sync_q <= '0;
            phi0_d <= 1'b0;
            phi0_r <= 1'b0;
            phi0_f <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bbc_phi0};
            phi0_d <= phi0_s;
            phi0_r <= phi0_s & ~phi0_d;
            phi0_f <= ~phi0_s & phi0_d;
        end
    end

endmodule

// File: rtl/bus_cycle_seq.sv
// Generates cpu_phi2 and steers each 65816 cycle either to fast local
// SRAM or to a host bus cycle stretched to align with host phi0.
module bus_cycle_seq
    import l1b_pkg::*;
#(
    parameter int FAST_DIV    = FAST_DIV_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic hsclk,
    input  logic rst,
    input  logic bbc_phi0,
    input  logic bbc_rdy,
    input  logic cpu_vda,
    input  logic cpu_vpa,
    input  logic cpu_rnw,
    input  logic sel_bbc,
    input  logic sel_ram,
    output logic cpu_phi2,
    output logic ram_ceb,
    output logic ram_oeb,
    output logic ram_web,
    output logic bbc_cyc,
    output logic bbc_dout_en,
    output logic rd_latch,
    output logic dsel_latch
);

    localparam int CNT_W = (FAST_DIV > 2) ? $clog2(FAST_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FAST_DIV - 1);

    seq_state_t       state;
    seq_state_t       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    bus_out_t         out_q;
    bus_out_t         out_n;

    logic phi0_r;
    logic phi0_f;
    logic cyc_valid;
    logic bbc_hit;
    logic ram_hit;
    logic last_cnt;

    phi0_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_phi0_sync (
        .hsclk    (hsclk),
        .rst      (rst),
        .bbc_phi0 (bbc_phi0),
        .phi0_r   (phi0_r),
        .phi0_f   (phi0_f)
    );

    // sel_bbc overrides sel_ram when the decoder flags both
    assign cyc_valid = cpu_vda | cpu_vpa;
    assign bbc_hit   = cyc_valid & sel_bbc;
    assign ram_hit   = cyc_valid & sel_ram & ~sel_bbc;
    assign last_cnt  = (cnt == CNT_LAST);

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        case (state)
            F_LO: begin
                if (last_cnt) begin
                    state_n = bbc_hit ? S_WAIT : F_HI;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            F_HI: begin
                if (last_cnt) begin
                    state_n = F_LO;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            // a rise here is ignored so the access spans a whole host cycle
            S_WAIT: begin
                if (phi0_f) begin
                    state_n = S_PH1;
                end
            end
            S_PH1: begin
                if (phi0_r) begin
                    state_n = S_PH2;
                end
            end
            S_PH2: begin
                if (phi0_f) begin
                    state_n = bbc_rdy ? S_END : S_PH1;
                end
            end
            S_END: begin
                state_n = F_LO;
            end
            default: begin
                state_n = F_LO;
            end
        endcase
    end

    // outputs follow the state being entered so they register cleanly
    always_comb begin
        out_n             = OUT_RST;
        out_n.cpu_phi2    = phi2_high(state_n);
        out_n.ram_ceb     = ~(is_fast(state_n) & ram_hit);
        out_n.ram_oeb     = ~((state_n == F_HI) & ram_hit & cpu_rnw);
        out_n.ram_web     = ~((state_n == F_HI) & (cnt_n != CNT_LAST)
                              & ram_hit & ~cpu_rnw);
        out_n.bbc_cyc     = (state_n == S_PH1) || (state_n == S_PH2);
        out_n.bbc_dout_en = (state_n == S_PH2) & ~cpu_rnw;
        out_n.rd_latch    = (state == S_PH2) & phi0_f & bbc_rdy & cpu_rnw;
        out_n.dsel_latch  = (state_n == S_END) & cpu_rnw;
    end

    always_ff @(posedge hsclk) begin
        if (rst) begin
            state <= F_LO;
            cnt   <= '0;
            out_q <= OUT_RST;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            out_q <= out_n;
        end
    end

    assign cpu_phi2    = out_q.cpu_phi2;
    assign ram_ceb     = out_q.ram_ceb;
    assign ram_oeb     = out_q.ram_oeb;
    assign ram_web     = out_q.ram_web;
    assign bbc_cyc     = out_q.bbc_cyc;
    assign bbc_dout_en = out_q.bbc_dout_en;
    assign rd_latch    = out_q.rd_latch;
    assign dsel_latch  = out_q.dsel_latch;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// Scoreboard bench: expected output runs (value, length) are queued by
// the stimulus and checked by a monitor each time the outputs change.
module tb_bus_cycle_seq;

    logic hsclk    = 1'b0;
    logic rst      = 1'b1;
    logic bbc_phi0 = 1'b0;
    logic bbc_rdy  = 1'b1;
    logic cpu_vda  = 1'b1;
    logic cpu_vpa  = 1'b0;
    logic cpu_rnw  = 1'b1;
    logic sel_bbc  = 1'b0;
    logic sel_ram  = 1'b1;

    logic cpu_phi2, ram_ceb, ram_oeb, ram_web;
    logic bbc_cyc, bbc_dout_en, rd_latch, dsel_latch;

    bus_cycle_seq dut (
        .hsclk       (hsclk),
        .rst         (rst),
        .bbc_phi0    (bbc_phi0),
        .bbc_rdy     (bbc_rdy),
        .cpu_vda     (cpu_vda),
        .cpu_vpa     (cpu_vpa),
        .cpu_rnw     (cpu_rnw),
        .sel_bbc     (sel_bbc),
        .sel_ram     (sel_ram),
        .cpu_phi2    (cpu_phi2),
        .ram_ceb     (ram_ceb),
        .ram_oeb     (ram_oeb),
        .ram_web     (ram_web),
        .bbc_cyc     (bbc_cyc),
        .bbc_dout_en (bbc_dout_en),
        .rd_latch    (rd_latch),
        .dsel_latch  (dsel_latch)
    );

    // {phi2, ceb, oeb, web, cyc, dout_en, rd_latch, dsel}
    localparam logic [7:0] V_R   = 8'b0111_0000;
    localparam logic [7:0] V_L   = 8'b0011_0000;
    localparam logic [7:0] V_H   = 8'b1001_0000;
    localparam logic [7:0] V_W   = 8'b1010_0000;
    localparam logic [7:0] V_H2  = 8'b1011_0000;
    localparam logic [7:0] V_Z   = 8'b0111_0000;
    localparam logic [7:0] V_F   = 8'b1111_0000;
    localparam logic [7:0] V_P1  = 8'b0111_1000;
    localparam logic [7:0] V_P2  = 8'b1111_1000;
    localparam logic [7:0] V_P2W = 8'b1111_1100;
    localparam logic [7:0] V_E   = 8'b1111_0011;

    typedef struct {
        logic [7:0] vec;
        int         len;
        string      tag;
    } run_t;

    run_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [7:0] obs;
    logic [7:0] cur;
    int         run_len;
    bit         first = 1'b1;

    assign obs = {cpu_phi2, ram_ceb, ram_oeb, ram_web,
                  bbc_cyc, bbc_dout_en, rd_latch, dsel_latch};

    always #5 hsclk = ~hsclk;

    always @(posedge hsclk) cyc <= cyc + 1;

    // host phi0: 16 hsclk period, edges placed off the hsclk edge
    initial begin
        forever begin
            repeat (8) @(posedge hsclk);
            #3 bbc_phi0 = ~bbc_phi0;
        end
    end

    task automatic push(input logic [7:0] v, input int len, input string tag);
        run_t r;
        r.vec = v;
        r.len = len;
        r.tag = tag;
        exp_q.push_back(r);
    endtask

    task automatic at(input int e);
        while (cyc < e) begin
            @(posedge hsclk);
            #1;
        end
    endtask

    task automatic check_run(input logic [7:0] v, input int len);
        run_t r;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_run: got %b x%0d, required no further run",
                     v, len);
        end else begin
            r = exp_q.pop_front();
            if (v !== r.vec || len != r.len) begin
                n_fail++;
                $display("FAIL %s: got %b x%0d, required %b x%0d",
                         r.tag, v, len, r.vec, r.len);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge hsclk);
            if (first) begin
                cur     = obs;
                run_len = 1;
                first   = 1'b0;
            end else if (obs !== cur) begin
                check_run(cur, run_len);
                cur     = obs;
                run_len = 1;
            end else begin
                run_len++;
            end
        end
    end

    initial begin
        push(V_R, 3, "reset_vals");
        push(V_L, 1, "ram_rd_first_lo");
        for (int i = 0; i < 3; i++) begin
            push(V_H, 2, "ram_rd_hi");
            push(V_L, 2, "ram_rd_lo");
        end
        for (int i = 0; i < 2; i++) begin
            push(V_W, 1, "ram_wr_web");
            push(V_H2, 1, "ram_wr_hold");
            if (i == 0) push(V_L, 2, "ram_wr_lo");
        end
        push(V_L, 1, "ram_wr_last_lo");
        at(3);
        rst = 1'b0;
        at(15);
        cpu_rnw = 1'b0;
        at(23);
        sel_bbc = 1'b1;
        sel_ram = 1'b0;
        cpu_rnw = 1'b1;

        push(V_Z, 12, "bbc_rd_wait");
        push(V_P1, 8, "bbc_rd_ph1");
        push(V_P2, 8, "bbc_rd_ph2");
        push(V_E, 1, "bbc_rd_end");
        at(52);
        sel_bbc = 1'b0;

        push(V_Z, 2, "fast_resume_lo");
        push(V_F, 2, "fast_resume_hi");
        push(V_Z, 11, "rdy_wait");
        push(V_P1, 8, "rdy_ph1_a");
        push(V_P2, 8, "rdy_ph2_a");
        push(V_P1, 8, "rdy_ph1_b");
        push(V_P2, 8, "rdy_ph2_b");
        push(V_E, 1, "rdy_end");
        at(57);
        sel_bbc = 1'b1;
        at(76);
        bbc_rdy = 1'b0;
        at(84);
        bbc_rdy = 1'b1;
        at(100);
        sel_bbc = 1'b0;

        push(V_Z, 2, "pre_wr_lo");
        push(V_F, 2, "pre_wr_hi");
        push(V_Z, 11, "bbc_wr_wait");
        push(V_P1, 8, "bbc_wr_ph1");
        push(V_P2W, 8, "bbc_wr_ph2");
        push(V_F, 1, "bbc_wr_end");
        at(105);
        sel_bbc = 1'b1;
        sel_ram = 1'b1;
        cpu_rnw = 1'b0;
        at(132);
        cpu_rnw = 1'b1;

        push(V_Z, 15, "abort_wait");
        push(V_P1, 8, "abort_ph1");
        push(V_P2, 3, "abort_ph2");
        push(V_R, 8, "abort_reset");
        at(158);
        rst = 1'b1;
        at(166);
        rst = 1'b0;
        sel_bbc = 1'b0;
        sel_ram = 1'b1;
        cpu_rnw = 1'b1;

        push(V_L, 1, "post_rst_lo");
        push(V_H, 2, "post_rst_hi");
        push(V_L, 2, "post_rst_lo2");
        push(V_H, 2, "post_rst_hi2");
        push(V_L, 2, "post_rst_lo3");
        at(177);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_runs: got %0d unmatched, required 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
